// File: rtl/jam_pkg.sv
// Shared types and sizing for the JAM search core cost-loading stage.
package jam_pkg;

    // The core is built for 8 workers / 8 jobs only, which fixes 3-bit indices.
    localparam int N       = 8;
    localparam int IDX_W   = 3;
    localparam int COST_W  = 7;
    localparam int LB_W    = 10;
    localparam int ADDR_W  = 2 * IDX_W;
    localparam int ENTRIES = N * N;

    typedef logic [COST_W-1:0] cost_t;
    typedef logic [ADDR_W-1:0] addr_t;

    // Largest representable cost; row minima start here so any real entry wins.
    localparam cost_t COST_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        SUM,
        DONE
    } ld_state_t;

endpackage

// File: rtl/jam_cost_rf.sv
// Local copy of the 8x8 cost table: one write port fed by the capture
// pipeline, one registered read port for the search core.
module jam_cost_rf
    import jam_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [COST_W-1:0] wdata,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_w,
    input  logic [IDX_W-1:0]  rd_j,
    output logic [COST_W-1:0] rd_cost
);

    // Table contents survive reset; only a completed load makes them meaningful.
    cost_t mem [ENTRIES];

    // Write port: one captured ROM word per valid capture cycle.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: returns zero until the table is complete, so the core never sees a half-loaded table.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_cost <= '0;
        end else if (rd_en) begin
            rd_cost <= mem[{rd_w, rd_j}];
        end else begin
            rd_cost <= '0;
        end
    end

endmodule

// File: rtl/jam_cost_loader.sv
// Streams the external 8x8 cost ROM into a local table, tracks per-worker
// row minima during the stream, and sums them into a pruning lower bound.
module jam_cost_loader
    import jam_pkg::*;
(
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    output logic [IDX_W-1:0]    W,
    output logic [IDX_W-1:0]    J,
    input  logic [COST_W-1:0]   Cost,
    output logic                load_busy,
    output logic                load_done,
    input  logic [IDX_W-1:0]    rd_w,
    input  logic [IDX_W-1:0]    rd_j,
    output logic [COST_W-1:0]   rd_cost,
    output logic [N*COST_W-1:0] row_min,
    output logic [LB_W-1:0]     lb_sum
);

    // Unsigned minimum of two costs.
    function automatic cost_t min_cost(input cost_t a, input cost_t b);
        return (b < a) ? b : a;
    endfunction

    // Sum of the packed row minima; 8 * 127 = 1016 always fits in LB_W bits.
    function automatic logic [LB_W-1:0] sum_rows(input logic [N*COST_W-1:0] v);
        logic [LB_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < N; i++) begin
            acc = acc + LB_W'(v[i*COST_W +: COST_W]);
        end
        return acc;
    endfunction

    ld_state_t state;
    ld_state_t state_nxt;

    // Stage p0 is the issued ROM address itself (it drives W/J); p1 is its
    // one-edge-delayed shadow, aligned with the ROM's data return.
    addr_t issue_p0;
    addr_t issue_nxt;
    logic  vld_p0;
    logic  vld_nxt;
    addr_t addr_p1;
    logic  vld_p1;
    logic  drain_ph;
    logic  start_acc;

    cost_t row_min_q [N];
    logic [IDX_W-1:0] cap_row;

    assign {W, J}    = issue_p0;
    assign load_busy = (state == FETCH) || (state == DRAIN) || (state == SUM);
    assign load_done = (state == DONE);
    assign start_acc = start && ((state == IDLE) || (state == DONE));
    assign cap_row   = addr_p1[ADDR_W-1:IDX_W];

    // Next-state and issue-address logic; W/J sit at zero outside FETCH.
    always_comb begin
        state_nxt = state;
        issue_nxt = '0;
        vld_nxt   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (issue_p0 == addr_t'(ENTRIES - 1)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_ph) begin
                    state_nxt = SUM;
                end
            end
            SUM: begin
                state_nxt = DONE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (state_nxt == FETCH) begin
            issue_nxt = (state == FETCH) ? (issue_p0 + addr_t'(1)) : '0;
            vld_nxt   = 1'b1;
        end
    end

    // Control registers: state, issued address, valid bits and the two-cycle drain phase.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            issue_p0 <= '0;
            vld_p0   <= 1'b0;
            vld_p1   <= 1'b0;
            drain_ph <= 1'b0;
        end else begin
            state    <= state_nxt;
            issue_p0 <= issue_nxt;
            vld_p0   <= vld_nxt;
            vld_p1   <= vld_p0;
            drain_ph <= (state == DRAIN) && !drain_ph;
        end
    end

    // ---- p0 -> p1: shadow the issued address while the ROM fetches the word ----
    always_ff @(posedge CLK) begin
        addr_p1 <= issue_p0;
    end

    // ---- p1 -> capture: Cost now belongs to addr_p1; fold it into its row minimum ----
    always_ff @(posedge CLK) begin
        if (RST || start_acc) begin
            for (int i = 0; i < N; i++) begin
                row_min_q[i] <= COST_MAX;
            end
        end else if (vld_p1) begin
            row_min_q[cap_row] <= min_cost(row_min_q[cap_row], Cost);
        end
    end

    // Pack the row minima, worker 0 in the low bits.
    always_comb begin
        row_min = '0;
        for (int i = 0; i < N; i++) begin
            row_min[i*COST_W +: COST_W] = row_min_q[i];
        end
    end

    // The lower bound is taken once, after the last capture has settled.
    always_ff @(posedge CLK) begin
        if (RST) begin
            lb_sum <= '0;
        end else if (state == SUM) begin
            lb_sum <= sum_rows(row_min);
        end
    end

    jam_cost_rf u_rf (
        .CLK     (CLK),
        .RST     (RST),
        .we      (vld_p1),
        .waddr   (addr_p1),
        .wdata   (Cost),
        .rd_en   (load_done),
        .rd_w    (rd_w),
        .rd_j    (rd_j),
        .rd_cost (rd_cost)
    );

endmodule

// File: tb/tb_jam_cost_loader.sv
// Bench for jam_cost_loader: a registered ROM model feeds Cost, and a
// table/row-minimum model derived from the ROM contents predicts the results.
module tb_jam_cost_loader;
    import jam_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  W, J;
    logic [6:0]  Cost;
    logic        load_busy, load_done;
    logic [2:0]  rd_w = '0, rd_j = '0;
    logic [6:0]  rd_cost;
    logic [55:0] row_min;
    logic [9:0]  lb_sum;

    int checks = 0;
    int failures = 0;

    int rom_tab [64];
    int tbl_exp [64];
    logic [6:0] rom_q;

    always #5 CLK = ~CLK;

    // External ROM: registers the address, so data trails W/J by two edges at the capture point.
    always @(posedge CLK) rom_q <= 7'(rom_tab[{W, J}]);
    assign Cost = rom_q;

    jam_cost_loader dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .W         (W),
        .J         (J),
        .Cost      (Cost),
        .load_busy (load_busy),
        .load_done (load_done),
        .rd_w      (rd_w),
        .rd_j      (rd_j),
        .rd_cost   (rd_cost),
        .row_min   (row_min),
        .lb_sum    (lb_sum)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Row minima and their sum straight from the table definition.
    task automatic model(output logic [55:0] rm, output int sum);
        rm = '0;
        sum = 0;
        for (int w = 0; w < 8; w++) begin
            int m;
            m = 127;
            for (int j = 0; j < 8; j++) begin
                if (tbl_exp[8*w+j] < m) m = tbl_exp[8*w+j];
            end
            rm[7*w +: 7] = 7'(m);
            sum += m;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_wj"}, {W, J}, 0);
        chk({tag, "_done"}, load_done, 0);
        chk({tag, "_busy"}, load_busy, 0);
        chk({tag, "_lb"}, lb_sum, 0);
        chk({tag, "_rd"}, rd_cost, 0);
        chk({tag, "_rowmin"}, row_min, 56'hFF_FFFF_FFFF_FFFF);
    endtask

    task automatic check_results(input string tag);
        logic [55:0] rm;
        int sum;
        model(rm, sum);
        chk({tag, "_rowmin"}, row_min, rm);
        chk({tag, "_lb"}, lb_sum, sum);
    endtask

    task automatic read_chk(input int w, input int j);
        rd_w = 3'(w);
        rd_j = 3'(j);
        tick();
        chk("readback", rd_cost, tbl_exp[8*w+j]);
    endtask

    // One load from a start pulse; abort_e>0 asserts RST before edge s+abort_e.
    task automatic do_load(input int abort_e, input bit pulses, input int exp_rd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_done_low", load_done, 0);
        chk("start_busy", load_busy, 1);
        chk("start_wj", {W, J}, 0);
        chk("rd_on_leave", rd_cost, exp_rd0);
        for (int e = 1; e <= 67; e++) begin
            start = pulses && (e == 10 || e == 66);
            RST = (e == abort_e);
            tick();
            start = 1'b0;
            RST = 1'b0;
            if (e == abort_e) begin
                check_reset_vals("abort");
                return;
            end
            chk("wj_seq", {W, J}, (e <= 63) ? e : 0);
            chk("done_time", load_done, (e == 67));
            if (e == 30) chk("rd_before_done", rd_cost, 0);
        end
        tbl_exp = rom_tab;
        check_results("load");
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            rom_tab[i] = 0;
            tbl_exp[i] = 0;
        end

        // Reset
        repeat (3) tick();
        RST = 1'b0;
        check_reset_vals("reset");

        // Ascending ROM
        for (int i = 0; i < 64; i++) rom_tab[i] = i;
        do_load(0, 1'b0, 0);
        chk("t2_lb", lb_sum, 224);
        chk("t2_row7", row_min[49 +: 7], 56);
        read_chk(5, 3);
        chk("t2_rd53", rd_cost, 43);

        // All-max and all-zero tables
        for (int i = 0; i < 64; i++) rom_tab[i] = 127;
        do_load(0, 1'b0, tbl_exp[43]);
        chk("t3_lb_max", lb_sum, 1016);
        chk("t3_rowmin_max", row_min, 56'hFF_FFFF_FFFF_FFFF);
        for (int i = 0; i < 64; i++) rom_tab[i] = 0;
        do_load(0, 1'b0, tbl_exp[43]);
        chk("t3_lb_zero", lb_sum, 0);

        // Ignored starts, then relaunch from DONE with a descending table
        for (int i = 0; i < 64; i++) rom_tab[i] = i;
        do_load(0, 1'b1, tbl_exp[43]);
        chk("t4_lb", lb_sum, 224);
        for (int i = 0; i < 64; i++) rom_tab[i] = 63 - i;
        do_load(0, 1'b0, tbl_exp[43]);
        chk("t4_lb_desc", lb_sum, 224);
        chk("t4_row0", row_min[0 +: 7], 56);
        chk("t4_row7", row_min[49 +: 7], 0);

        // Reset mid-load, then a clean reload
        for (int i = 0; i < 64; i++) rom_tab[i] = i;
        do_load(30, 1'b0, tbl_exp[43]);
        do_load(0, 1'b0, 0);
        chk("t5_lb", lb_sum, 224);
        read_chk(5, 3);
        chk("t5_rd53", rd_cost, 43);

        // Random tables with full readback
        for (int n = 0; n < 20; n++) begin
            int rw, rj;
            for (int i = 0; i < 64; i++) rom_tab[i] = int'($urandom_range(0, 127));
            rw = int'($urandom_range(0, 7));
            rj = int'($urandom_range(0, 7));
            rd_w = 3'(rw);
            rd_j = 3'(rj);
            do_load(0, 1'b0, tbl_exp[8*rw+rj]);
            for (int a = 0; a < 64; a++) read_chk(a / 8, a % 8);
        end

        // RST and start together: reset wins
        RST = 1'b1;
        start = 1'b1;
        tick();
        RST = 1'b0;
        start = 1'b0;
        check_reset_vals("rst_vs_start");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
